// File: rtl/hamming_uart_responder.sv
// Far-end responder: receives an 8N1 byte holding a Hamming(7,4) code word, corrects single-bit
// errors, exposes the decoded nibble and answers with one status/echo byte on its own TX line.
module hamming_uart_responder #(
   parameter int unsigned CLKS_PER_BIT = 16,
   parameter logic [7:0]  NAK_BYTE     = 8'h80
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic       rx,
   output logic       tx,
   output logic [3:0] data_out,
   output logic [2:0] syndrome_out,
   output logic       valid_out,
   output logic       frame_err,
   output logic       busy
);

   localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

   typedef enum logic [2:0] {
      IDLE, START, DATA, STOP, DECODE, TX_START, TX_DATA, TX_STOP
   } state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       bit_q, bit_d;
   logic             rx_meta_q, rx_meta_d, rxs_q, rxs_d;
   logic             armed_q, armed_d;
   logic [7:0]       rx_byte_q, rx_byte_d;
   logic [7:0]       tx_shift_q, tx_shift_d;
   logic             tx_q, tx_d;
   logic [3:0]       data_q, data_d;
   logic [2:0]       syn_q, syn_d;
   logic             valid_q, valid_d, ferr_q, ferr_d, busy_q, busy_d;

   // Syndrome over positions 1..7 (code[p-1]); the data bits sit at positions 3,5,6,7.
   logic [2:0] syn;
   logic [3:0] nibble;

   always_comb begin
      syn[0] = rx_byte_q[0] ^ rx_byte_q[2] ^ rx_byte_q[4] ^ rx_byte_q[6];
      syn[1] = rx_byte_q[1] ^ rx_byte_q[2] ^ rx_byte_q[5] ^ rx_byte_q[6];
      syn[2] = rx_byte_q[3] ^ rx_byte_q[4] ^ rx_byte_q[5] ^ rx_byte_q[6];
      nibble = {rx_byte_q[6], rx_byte_q[5], rx_byte_q[4], rx_byte_q[2]}
             ^ {syn == 3'd7, syn == 3'd6, syn == 3'd5, syn == 3'd3};
   end

   always_comb begin
      // NOTE: every *_d gets a default first so no path through the case infers a latch.
      state_d    = state_q;
      cnt_d      = cnt_q;
      bit_d      = bit_q;
      rx_meta_d  = rx;
      rxs_d      = rx_meta_q;
      armed_d    = 1'b0;
      rx_byte_d  = rx_byte_q;
      tx_shift_d = tx_shift_q;
      tx_d       = tx_q;
      data_d     = data_q;
      syn_d      = syn_q;
      valid_d    = 1'b0;
      ferr_d     = 1'b0;
      busy_d     = busy_q;

      unique case (state_q)
         IDLE: begin
            // A start needs a high line seen in IDLE first; a line already low is ignored.
            armed_d = rxs_q;
            cnt_d   = '0;
            if (armed_q && !rxs_q) begin
               state_d = START;
               busy_d  = 1'b1;
            end
         end
         START: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == HALF_LAST) begin
               cnt_d = '0;
               bit_d = '0;
               if (rxs_q) begin
                  state_d = IDLE;
                  busy_d  = 1'b0;
               end else begin
                  state_d = DATA;
               end
            end
         end
         DATA: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == BIT_LAST) begin
               cnt_d     = '0;
               rx_byte_d = {rxs_q, rx_byte_q[7:1]};
               bit_d     = bit_q + 3'd1;
               if (bit_q == 3'd7) state_d = STOP;
            end
         end
         STOP: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == BIT_LAST) begin
               cnt_d = '0;
               if (rxs_q) begin
                  state_d = DECODE;
               end else begin
                  state_d = IDLE;
                  ferr_d  = 1'b1;
                  busy_d  = 1'b0;
               end
            end
         end
         DECODE: begin
            if (!rx_byte_q[7]) begin
               data_d     = nibble;
               syn_d      = syn;
               valid_d    = 1'b1;
               tx_shift_d = {syn != 3'd0, syn, nibble};
            end else begin
               tx_shift_d = NAK_BYTE;
            end
            tx_d    = 1'b0;
            cnt_d   = '0;
            state_d = TX_START;
         end
         TX_START: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == BIT_LAST) begin
               cnt_d   = '0;
               bit_d   = '0;
               tx_d    = tx_shift_q[0];
               state_d = TX_DATA;
            end
         end
         TX_DATA: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == BIT_LAST) begin
               cnt_d = '0;
               if (bit_q == 3'd7) begin
                  tx_d    = 1'b1;
                  state_d = TX_STOP;
               end else begin
                  bit_d      = bit_q + 3'd1;
                  tx_shift_d = {1'b0, tx_shift_q[7:1]};
                  tx_d       = tx_shift_q[1];
               end
            end
         end
         TX_STOP: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == BIT_LAST) begin
               cnt_d   = '0;
               busy_d  = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         bit_q      <= '0;
         rx_meta_q  <= 1'b1;
         rxs_q      <= 1'b1;
         armed_q    <= 1'b0;
         rx_byte_q  <= '0;
         tx_shift_q <= '0;
         tx_q       <= 1'b1;
         data_q     <= '0;
         syn_q      <= '0;
         valid_q    <= 1'b0;
         ferr_q     <= 1'b0;
         busy_q     <= 1'b0;
      end else if (ena) begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         bit_q      <= bit_d;
         rx_meta_q  <= rx_meta_d;
         rxs_q      <= rxs_d;
         armed_q    <= armed_d;
         rx_byte_q  <= rx_byte_d;
         tx_shift_q <= tx_shift_d;
         tx_q       <= tx_d;
         data_q     <= data_d;
         syn_q      <= syn_d;
         valid_q    <= valid_d;
         ferr_q     <= ferr_d;
         busy_q     <= busy_d;
      end
   end

   // Pulses stay pending in their flops while frozen and appear on the first enabled cycle.
   assign tx           = tx_q;
   assign data_out     = data_q;
   assign syndrome_out = syn_q;
   assign valid_out    = valid_q & ena;
   assign frame_err    = ferr_q & ena;
   assign busy         = busy_q;

endmodule

// File: tb/tb_hamming_uart_responder.sv
// Directed bench for hamming_uart_responder: table of received bytes with hand-decoded results,
// plus sequences for false start, RX during response, reset mid-response and ena freeze.
module tb_hamming_uart_responder;

   localparam int CPB = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       ena = 1'b1;
   logic       rx = 1'b1;
   logic       tx;
   logic [3:0] data_out;
   logic [2:0] syndrome_out;
   logic       valid_out, frame_err, busy;

   hamming_uart_responder #(.CLKS_PER_BIT(CPB), .NAK_BYTE(8'h80)) dut (
      .clk(clk), .rst_n(rst_n), .ena(ena), .rx(rx), .tx(tx),
      .data_out(data_out), .syndrome_out(syndrome_out),
      .valid_out(valid_out), .frame_err(frame_err), .busy(busy)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Negedge monitor: pulse counters and a UART decoder for the response line.
   int         cyc = 0;
   int         valid_cnt = 0, ferr_cnt = 0, resp_cnt = 0;
   int         valid_cyc = -1, tx_start_cyc = -1;
   int         mon_off = -1;
   logic [7:0] mon_byte, resp_byte;
   logic       mon_stop, resp_stop, mon_b39, resp_busy_ok;

   always @(negedge clk) begin
      cyc++;
      if (valid_out === 1'b1) begin valid_cnt++; valid_cyc = cyc; end
      if (frame_err === 1'b1) ferr_cnt++;
      if (!rst_n) begin
         mon_off = -1;
      end else if (mon_off < 0) begin
         if (tx === 1'b0) begin mon_off = 0; tx_start_cyc = cyc; end
      end else begin
         mon_off++;
         if (mon_off >= 6 && mon_off <= 34 && (mon_off % 4) == 2) mon_byte[(mon_off - 6) / 4] = tx;
         if (mon_off == 38) mon_stop = tx;
         if (mon_off == 39) mon_b39 = busy;
         if (mon_off == 40) begin
            resp_byte    = mon_byte;
            resp_stop    = mon_stop;
            resp_busy_ok = mon_b39 && !busy;
            resp_cnt++;
            mon_off = -1;
         end
      end
   end

   task automatic send_byte(input logic [7:0] b, input logic stop, input bit freeze);
      logic [9:0] f;
      f = {stop, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         for (int c = 0; c < CPB; c++) begin
            @(posedge clk);
            rx = f[i];
            if (freeze && i == 3 && c == 1) begin
               ena = 1'b0;
               repeat (10) @(posedge clk);
               #1 check("frozen_busy", busy, 1'b1);
               check("frozen_valid", valid_out, 1'b0);
               repeat (10) @(posedge clk);
               ena = 1'b1;
            end
         end
      end
      @(posedge clk);
      rx = 1'b1;
   endtask

   task automatic wait_resp(input int prev, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (resp_cnt > prev) begin ok = 1'b1; break; end
      end
   endtask

   task automatic wait_tx_low(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (tx === 1'b0) begin ok = 1'b1; break; end
      end
   endtask

   typedef struct {
      logic [7:0] rx_byte;
      logic       stop;
      logic       exp_valid;
      logic       exp_ferr;
      logic       exp_resp;
      logic [3:0] exp_data;
      logic [2:0] exp_syn;
      logic [7:0] exp_tx;
   } vec_t;

   vec_t vecs[9];

   initial begin
      int v0, f0, r0;
      bit ok, seen;

      //          rx     stop valid ferr resp data  syn   tx
      vecs[0] = '{8'h55, 1'b1, 1'b1, 1'b0, 1'b1, 4'hB, 3'd0, 8'h0B};
      vecs[1] = '{8'h45, 1'b1, 1'b1, 1'b0, 1'b1, 4'hB, 3'd5, 8'hDB};
      vecs[2] = '{8'hD5, 1'b1, 1'b0, 1'b0, 1'b1, 4'hB, 3'd5, 8'h80};
      vecs[3] = '{8'h55, 1'b0, 1'b0, 1'b1, 1'b0, 4'hB, 3'd5, 8'h00};
      vecs[4] = '{8'h55, 1'b1, 1'b1, 1'b0, 1'b1, 4'hB, 3'd0, 8'h0B};
      vecs[5] = '{8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 4'h0, 3'd0, 8'h00};
      vecs[6] = '{8'h01, 1'b1, 1'b1, 1'b0, 1'b1, 4'h0, 3'd1, 8'h90};
      vecs[7] = '{8'h7F, 1'b1, 1'b1, 1'b0, 1'b1, 4'hF, 3'd0, 8'h0F};
      vecs[8] = '{8'h3F, 1'b1, 1'b1, 1'b0, 1'b1, 4'hF, 3'd7, 8'hFF};

      repeat (3) @(negedge clk);
      check("rst_tx", tx, 1'b1);
      check("rst_busy", busy, 1'b0);
      check("rst_data", data_out, 4'h0);
      check("rst_syn", syndrome_out, 3'd0);
      check("rst_valid", valid_out, 1'b0);
      check("rst_ferr", frame_err, 1'b0);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);

      for (int i = 0; i < 9; i++) begin
         v0 = valid_cnt; f0 = ferr_cnt; r0 = resp_cnt;
         send_byte(vecs[i].rx_byte, vecs[i].stop, 1'b0);
         if (vecs[i].exp_resp) begin
            wait_resp(r0, ok);
            check($sformatf("v%0d_resp_seen", i), ok, 1'b1);
            check($sformatf("v%0d_resp_byte", i), resp_byte, vecs[i].exp_tx);
            check($sformatf("v%0d_resp_stop", i), resp_stop, 1'b1);
            check($sformatf("v%0d_busy_end", i), resp_busy_ok, 1'b1);
            if (vecs[i].exp_valid) check($sformatf("v%0d_latency", i), tx_start_cyc, valid_cyc);
         end else begin
            repeat (20 * CPB) @(negedge clk);
         end
         repeat (4) @(negedge clk);
         check($sformatf("v%0d_valid_cnt", i), valid_cnt - v0, vecs[i].exp_valid);
         check($sformatf("v%0d_ferr_cnt", i), ferr_cnt - f0, vecs[i].exp_ferr);
         check($sformatf("v%0d_resp_cnt", i), resp_cnt - r0, vecs[i].exp_resp);
         check($sformatf("v%0d_data", i), data_out, vecs[i].exp_data);
         check($sformatf("v%0d_syn", i), syndrome_out, vecs[i].exp_syn);
         check($sformatf("v%0d_idle", i), {busy, tx}, 2'b01);
      end

      // One-cycle glitch: false start, busy rises then falls, nothing else happens.
      v0 = valid_cnt; f0 = ferr_cnt; r0 = resp_cnt; seen = 1'b0;
      @(posedge clk); rx = 1'b0;
      @(posedge clk); rx = 1'b1;
      repeat (30) begin @(negedge clk); seen |= busy; end
      check("glitch_busy_seen", seen, 1'b1);
      check("glitch_busy_end", busy, 1'b0);
      check("glitch_quiet", {valid_cnt - v0, ferr_cnt - f0, resp_cnt - r0}, 96'd0);

      // A frame sent while the response is on the wire must be ignored.
      v0 = valid_cnt; r0 = resp_cnt;
      send_byte(8'h55, 1'b1, 1'b0);
      wait_tx_low(ok);
      check("ovl_tx_start", ok, 1'b1);
      repeat (4) @(negedge clk);
      send_byte(8'h7F, 1'b1, 1'b0);
      repeat (120) @(negedge clk);
      check("ovl_resp_cnt", resp_cnt - r0, 1);
      check("ovl_valid_cnt", valid_cnt - v0, 1);
      check("ovl_resp_byte", resp_byte, 8'h0B);
      check("ovl_data", {data_out, 1'b0, syndrome_out}, {4'hB, 1'b0, 3'd0});
      check("ovl_busy", busy, 1'b0);

      // Reset in the middle of TX_DATA: tx and busy recover at once, no response completes.
      r0 = resp_cnt;
      send_byte(8'h55, 1'b1, 1'b0);
      wait_tx_low(ok);
      check("rst_tx_start", ok, 1'b1);
      repeat (10) @(negedge clk);
      check("rst_pre_tx_busy", busy, 1'b1);
      rst_n = 1'b0;
      #1;
      check("rst_mid_tx", tx, 1'b1);
      check("rst_mid_busy", busy, 1'b0);
      repeat (3) @(negedge clk);
      check("rst_mid_data", data_out, 4'h0);
      rst_n = 1'b1;
      repeat (60) @(negedge clk);
      check("rst_mid_resp_cnt", resp_cnt - r0, 0);

      // Freeze for 20 cycles in the middle of DATA; the frame must still decode.
      v0 = valid_cnt; r0 = resp_cnt;
      send_byte(8'h45, 1'b1, 1'b1);
      wait_resp(r0, ok);
      check("frz_resp_seen", ok, 1'b1);
      check("frz_resp_byte", resp_byte, 8'hDB);
      check("frz_latency", tx_start_cyc, valid_cyc);
      repeat (4) @(negedge clk);
      check("frz_valid_cnt", valid_cnt - v0, 1);
      check("frz_data", data_out, 4'hB);
      check("frz_syn", syndrome_out, 3'd5);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

endmodule

// File: doc/hamming_uart_responder.md
Name: hamming_uart_responder

Overview:
Far-end responder for the Hamming(7,4)-over-UART link. It receives one 8N1 byte carrying a 7-bit Hamming code (bit 7 is padding, 0), corrects any single-bit error and exposes the decoded nibble locally. It then transmits a one-byte status/echo response back on its own TX line, so the initiator can confirm delivery. Half-duplex: RX is ignored while a response is being sent.

Parameters:
CLKS_PER_BIT, 16, clock cycles per UART bit (>=4, even)
NAK_BYTE, 8'h80, response sent when padding bit 7 of the received byte is 1

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
ena  input  1  0 freezes all state (counters, FSM, tx level held)
rx  input  1  UART serial in, idle high, asynchronous to clk
tx  output  1  UART serial out, idle high
data_out  output  4  last corrected data nibble {d3,d2,d1,d0}
syndrome_out  output  3  last syndrome {s4,s2,s1}
valid_out  output  1  1-cycle pulse when data_out/syndrome_out update
frame_err  output  1  1-cycle pulse on bad stop bit
busy  output  1  high from accepted start bit until end of response stop bit

Behaviour:
- Interface: one clock, clk; reset rst_n, asynchronous, active-low. Reset: tx=1, data_out=0, syndrome_out=0, valid_out=0, frame_err=0, busy=0, FSM=IDLE, counters=0. Reset mid-frame or mid-response aborts immediately; tx returns high the same cycle.
- rx passes a 2-FF synchronizer (reset value 1); all decisions use the synchronized value rxs.
- FSM states: IDLE, START, DATA, STOP, DECODE, TX_START, TX_DATA, TX_STOP.
- IDLE: on rxs falling edge (prev 1, now 1->0) go START, busy=1.
- START: wait CLKS_PER_BIT/2 cycles; if rxs=1 then false start -> IDLE, busy=0; else go DATA with bit counter=0.
- DATA: sample rxs every CLKS_PER_BIT cycles, LSB first, into rx_byte; after 8th sample go STOP.
- STOP: after CLKS_PER_BIT cycles sample rxs; 1 -> DECODE; 0 -> frame_err pulse, busy=0, IDLE, outputs unchanged, no response.
- Code mapping (position p = 1..7): code[p-1]; p1=code[0], p2=code[1], d0=code[2], p4=code[3], d1=code[4], d2=code[5], d3=code[6].
- Syndrome: s1 = xor of positions 1,3,5,7; s2 = xor of 2,3,6,7; s4 = xor of 4,5,6,7. Nonzero S={s4,s2,s1} flips position S before data extraction.
- DECODE (1 cycle): if rx_byte[7]=0, register data_out, syndrome_out, pulse valid_out; response = {S!=0, S, corrected nibble}. If rx_byte[7]=1, data_out, syndrome_out and valid_out are unchanged; response = NAK_BYTE. Note: 8'h80 cannot arise from a valid byte.
- TX_START: tx=0 for CLKS_PER_BIT cycles. TX_DATA: 8 bits LSB first, CLKS_PER_BIT each. TX_STOP: tx=1 for CLKS_PER_BIT cycles, then busy=0, IDLE.
- Latency: first tx start-bit cycle is the cycle after DECODE. The response frame is exactly 10*CLKS_PER_BIT cycles long.
- A falling edge on rxs during any TX_* state is ignored. No reception begins until IDLE is re-entered with rxs=1 seen at least once; an rx line that is already low is not treated as a start bit.
- ena=0: every register holds, including synchronizer and counters; valid_out/frame_err forced 0 while ena=0. Pulses are not lost: a pulse due on a frozen cycle fires on the first enabled cycle.

Test Plan:
- CLKS_PER_BIT=4; send 0x55 (data 1011, clean) -> valid_out pulse, data_out=4'hB, syndrome_out=0, tx frame 0x0B, busy high start-edge to response stop end.
- Send 0x45 (0x55 with position 5 flipped) -> data_out=4'hB, syndrome_out=3'd5, response 0xDB.
- Send 0xD5 (padding bit set) -> no valid_out, outputs keep previous values, response 0x80.
- Send 0x55 with stop bit 0 -> frame_err single pulse, no valid_out, tx stays 1, busy drops, next good 0x55 frame decoded normally.
- Glitch rx low for 1 cycle in IDLE -> false start, no outputs, busy returns 0; send byte during response TX -> ignored, exactly one response.
- Assert rst_n low mid TX_DATA -> tx=1 and busy=0 immediately; hold ena=0 mid-DATA for 20 cycles -> frame still decoded correctly after resume.
